nibble_serial_adder: RTL and testbench



---
 rtl/adder_pkg.sv | 30 +++
 rtl/nibble_serial_adder_adder4b.sv | 33 +++
 rtl/nibble_serial_adder.sv | 132 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the nibble-serial adder:
//   NIBBLE_W  width of one adder slice (4 bits)
//   state_t   FSM encoding IDLE/RUN/DONE in a 2-bit register
//   clog2     ceiling log2, used to size the nibble index counter
// ---------------------------------------------------------------------------
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r such that 2**r >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_adder4b.sv
// ---------------------------------------------------------------------------
// Adder4b
// Combinational 4-bit ripple-carry adder slice.
// Ports:
//   A, B  : 4-bit operands
//   Ci    : carry in
//   S     : 4-bit sum (A+B+Ci mod 16)
//   Co    : carry out of bit 3
// ---------------------------------------------------------------------------
module Adder4b
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] A,
    input  logic [NIBBLE_W-1:0] B,
    input  logic                Ci,
    output logic [NIBBLE_W-1:0] S,
    output logic                Co
);

    logic [NIBBLE_W:0] w_c;

    assign w_c[0] = Ci;

    generate
        for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
            assign S[gi]       = A[gi] ^ B[gi] ^ w_c[gi];
            assign w_c[gi + 1] = (A[gi] & B[gi]) | (A[gi] & w_c[gi]) | (B[gi] & w_c[gi]);
        end
    endgenerate

    assign Co = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
// Multi-cycle W-bit adder (W = 4*NIBBLES) that reuses one Adder4b slice,
// processing one operand nibble per clock, LSB nibble first. The carry
// between nibbles is registered. Result handed off on valid/ready.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake (ready only in IDLE)
//   a, b, ci              : W-bit operands and carry-in
//   out_valid / out_ready : result handshake (valid only in DONE)
//   sum, co, ovf          : W-bit sum, unsigned carry out, signed overflow
// ---------------------------------------------------------------------------
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      ci,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      co,
    output logic                      ovf
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = clog2(NIBBLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_co;
    logic               r_ovf;
    // Operand sign bits, kept because the shift registers lose them.
    logic               r_a_msb;
    logic               r_b_msb;

    logic               w_accept;
    logic               w_last;
    logic [NIBBLE_W-1:0] w_s;
    logic               w_co;

    Adder4b u_adder4b (
        .A  (r_a[NIBBLE_W-1:0]),
        .B  (r_b[NIBBLE_W-1:0]),
        .Ci (r_carry),
        .S  (w_s),
        .Co (w_co)
    );

    // Next-state and handshake decode.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_idx == LAST_IDX) begin
                    w_last       = 1'b1;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_ovf   <= 1'b0;
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= ci;
                r_idx   <= '0;
                r_a_msb <= a[W-1];
                r_b_msb <= b[W-1];
            end else if (r_state == RUN) begin
                // New slice result enters at the top; after NIBBLES steps
                // the first slice has been shifted down to bits [3:0].
                r_sum   <= (r_sum >> NIBBLE_W) | (W'(w_s) << (W - NIBBLE_W));
                r_carry <= w_co;
                r_a     <= r_a >> NIBBLE_W;
                r_b     <= r_b >> NIBBLE_W;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_co  <= w_co;
                    r_ovf <= (r_a_msb == r_b_msb) && (w_s[NIBBLE_W-1] != r_a_msb);
                end
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign co        = r_co;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    logic        clk;
    logic        rst;

    // NIBBLES=4 instance
    logic        in_valid, in_ready, out_valid, out_ready, ci, co, ovf;
    logic [15:0] a, b, sum;

    // NIBBLES=1 instance
    logic        in_valid1, in_ready1, out_valid1, out_ready1, ci1, co1, ovf1;
    logic [3:0]  a1, b1, sum1;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb4[$];
    exp_t sb1[$];

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ci(ci),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .co(co), .ovf(ovf)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .ci(ci1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .co(co1), .ovf(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide addition, signed overflow from operand/sum signs.
    function automatic exp_t model16(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] t;
        exp_t e;
        t     = {1'b0, x} + {1'b0, y} + {16'd0, c};
        e.s   = t[15:0];
        e.co  = t[16];
        e.ovf = (x[15] == y[15]) && (t[15] != x[15]);
        return e;
    endfunction

    // One NIBBLES=4 operation. hold>0 applies back-pressure for that many
    // cycles while junk operands are waved at the input.
    task automatic run_op4(input string name, input logic [15:0] xa, input logic [15:0] xb,
                           input logic xc, input exp_t e, input int hold);
        int   lat;
        exp_t got;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        a = xa; b = xb; ci = xc; in_valid = 1'b1; out_ready = (hold == 0);
        sb4.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, ".latency"}, 32'(lat), 32'd4);
        if (sb4.size() == 0) begin
            check({name, ".scoreboard"}, 32'd0, 32'd1);
        end else begin
            got = sb4.pop_front();
            check({name, ".sum"}, 32'(sum), 32'(got.s));
            check({name, ".co"},  32'(co),  32'(got.co));
            check({name, ".ovf"}, 32'(ovf), 32'(got.ovf));
            for (int i = 0; i < hold; i++) begin
                in_valid = i[0];
                a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
                @(negedge clk);
                check({name, ".bp_valid"}, 32'(out_valid), 32'd1);
                check({name, ".bp_ready"}, 32'(in_ready), 32'd0);
                check({name, ".bp_sum"},   32'(sum), 32'(got.s));
                check({name, ".bp_co"},    32'(co),  32'(got.co));
                check({name, ".bp_ovf"},   32'(ovf), 32'(got.ovf));
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, ".idle_ready"}, 32'(in_ready), 32'd1);
        check({name, ".idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op1(input string name, input logic [3:0] xa, input logic [3:0] xb,
                           input logic xc, input exp_t e);
        int   lat;
        exp_t got;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(in_ready1), 32'd1);
        a1 = xa; b1 = xb; ci1 = xc; in_valid1 = 1'b1; out_ready1 = 1'b1;
        sb1.push_back(e);
        @(negedge clk);
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, ".latency"}, 32'(lat), 32'd1);
        if (sb1.size() == 0) begin
            check({name, ".scoreboard"}, 32'd0, 32'd1);
        end else begin
            got = sb1.pop_front();
            check({name, ".sum"}, 32'(sum1), 32'(got.s[3:0]));
            check({name, ".co"},  32'(co1),  32'(got.co));
            check({name, ".ovf"}, 32'(ovf1), 32'(got.ovf));
        end
        @(negedge clk);
        check({name, ".idle_ready"}, 32'(in_ready1), 32'd1);
    endtask

    initial begin
        vec_t vecs[8];
        exp_t e;
        logic [15:0] ra, rb;
        logic        rc;
        int          lat;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};

        rst = 1'b1;
        in_valid = 0; out_ready = 1; a = 0; b = 0; ci = 0;
        in_valid1 = 0; out_ready1 = 1; a1 = 0; b1 = 0; ci1 = 0;
        repeat (3) @(negedge clk);
        check("reset.in_ready",  32'(in_ready),  32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.co",        32'(co),        32'd0);
        check("reset.ovf",       32'(ovf),       32'd0);
        check("reset1.in_ready", 32'(in_ready1), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e.s = vecs[i].s; e.co = vecs[i].co; e.ovf = vecs[i].ovf;
            run_op4($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, e, 0);
            $display("vec%0d a=%h b=%h ci=%0d -> sum=%h co=%0d ovf=%0d", i,
                     vecs[i].a, vecs[i].b, vecs[i].ci, sum, co, ovf);
        end

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            run_op4($sformatf("rand%0d", i), ra, rb, rc, model16(ra, rb, rc), 0);
            $display("rand%0d a=%h b=%h ci=%0d -> sum=%h", i, ra, rb, rc, sum);
        end

        // Back-pressure: 10 cycles stalled in DONE.
        e.s = 16'h5555; e.co = 1'b0; e.ovf = 1'b0;
        run_op4("bp", 16'h1234, 16'h4321, 1'b0, e, 10);
        $display("bp held 10 cycles sum=%h", sum);

        // Leave co/ovf set, then reset partway through RUN.
        e.s = 16'h0000; e.co = 1'b1; e.ovf = 1'b1;
        run_op4("preset", 16'h8000, 16'h8000, 1'b0, e, 0);
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; ci = 0; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        check("midrst.running", 32'(in_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.in_ready",  32'(in_ready),  32'd1);
        check("midrst.co",        32'(co),        32'd0);
        check("midrst.ovf",       32'(ovf),       32'd0);
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check("midrst.no_result", 32'(out_valid), 32'd0);
        $display("midrst discarded partial result");
        e.s = 16'h0007; e.co = 1'b0; e.ovf = 1'b0;
        run_op4("after_rst", 16'h0003, 16'h0004, 1'b0, e, 0);
        $display("after_rst sum=%h", sum);

        // NIBBLES=1 instance.
        e.s = 16'h0007; e.co = 1'b0; e.ovf = 1'b0;
        run_op1("n1_a", 4'd3, 4'd4, 1'b0, e);
        $display("n1_a 3+4 -> sum=%0d", sum1);
        e.s = 16'h0002; e.co = 1'b1; e.ovf = 1'b1;
        run_op1("n1_b", 4'd10, 4'd8, 1'b0, e);
        $display("n1_b 10+8 -> sum=%0d co=%0d ovf=%0d", sum1, co1, ovf1);

        check("scoreboard4.empty", 32'(sb4.size()), 32'd0);
        check("scoreboard1.empty", 32'(sb1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
